multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle op sequencer: counts a per-class latency from a small config table,
// then emits a one-cycle done pulse. Supports stall (freeze) and flush (squash).
module multicycle_sequencer #(
  parameter int CTR_W       = 4,
  parameter int DEFAULT_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CTR_W-1:0] cfg_data,
  input  logic             issue_valid,
  input  logic [1:0]       issue_class,
  output logic             issue_ready,
  input  logic             flush,
  input  logic             stall,
  output logic             hold,
  output logic [CTR_W-1:0] cur_cnt,
  output logic             done,
  output logic [1:0]       done_class
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CTR_W-1:0] lat_tab [4];
  logic [CTR_W-1:0] count;
  logic [CTR_W-1:0] stop;
  logic [1:0]       cls;
  logic             accept;

  assign accept  = issue_valid && issue_ready;
  assign cur_cnt = count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? COUNT : IDLE;
      COUNT: begin
        if (flush)              state_nxt = IDLE;
        else if (stall)         state_nxt = COUNT;
        else if (count == stop) state_nxt = DONE;
        else                    state_nxt = COUNT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state == IDLE) && !flush;
    hold        = (state == COUNT);
    done        = (state == DONE) && !flush;
    done_class  = cls;
  end

  // Count never passes stop, so an all-ones latency cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (state)
        IDLE:  if (accept) count <= '0;
        COUNT: begin
          if (flush)                      count <= '0;
          else if (!stall && count != stop) count <= count + CTR_W'(1);
        end
        DONE:    count <= '0;
        default: count <= '0;
      endcase
    end
  end

  // Stop and class are latched at acceptance so later table writes cannot
  // disturb the op in flight; the table read here sees the pre-write value.
  always_ff @(posedge clk) begin
    if (accept) begin
      stop <= lat_tab[issue_class];
      cls  <= issue_class;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) lat_tab[i] <= CTR_W'(DEFAULT_LAT);
    end else if (cfg_we) begin
      lat_tab[cfg_addr] <= cfg_data;
    end
  end

endmodule
